fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder stage directly downstream of the 512-point, 16-lane radix butterfly pipeline.
- Consumes the butterfly's bit-reversed-order output: 32 beats of 16 complex samples per frame.
- Buffers each frame in a ping-pong pair of banks and replays it in natural frequency order, 16 samples per beat.
- Streams at full rate with no backpressure; frames may arrive back-to-back.

Parameters:
- NUM, 16, complex samples per beat (lanes)
- N, 512, samples per frame (N/NUM = 32 beats)
- DW, 10, signed width of each I or Q sample (butterfly output format)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  synchronous active-low reset
- valid_in  in  1  input beat qualifier; one beat per clk where high
- din_i  in  DW*NUM  packed I samples; lane j at [j*DW +: DW]
- din_q  in  DW*NUM  packed Q samples, same packing
- valid_out  out  1  output beat qualifier
- sof_out  out  1  high on beat 0 of each output frame only
- dout_i  out  DW*NUM  packed I samples, natural order
- dout_q  out  DW*NUM  packed Q samples, natural order

Behaviour:
- One clock; reset is synchronous and active-low. rstn is sampled on the rising edge of clk.
- Reset state:
  - valid_out=0, sof_out=0, dout_i=dout_q=0.
  - Write beat counter = 0, read beat counter = 0, write bank = 0.
  - Both bank-full flags = 0; read FSM = IDLE.
  - Bank storage is not reset.
- Input ordering:
  - Input beat c (0..31) lane j carries natural index p = bitrev9(c*16+j), which equals rev4(j)*32 + rev5(c).
  - The sample is written to bank location p.
- Write side:
  - The write beat counter increments only on valid_in=1, so gaps are allowed mid-frame.
  - On beat 31:
    - set full[wbank];
    - toggle wbank;
    - wrap the counter to 0.
- Read FSM states: IDLE, READ.
  - IDLE -> READ when full[rbank]=1. The check includes a flag being set on the same edge: beat 31 written at edge e starts the read at edge e+1.
  - In READ, each edge loads output beat k (k=0..31): lane m = bank[rbank][16k+m].
  - At k=31:
    - clear full[rbank] and toggle rbank;
    - if full of the new rbank is already 1, stay in READ with k=0, giving back-to-back frames with no gap;
    - otherwise go to IDLE.
- Latency and output registers:
  - Last input beat sampled at edge e; the first output beat is registered at edge e+1.
  - valid_out stays high for exactly 32 consecutive cycles per frame.
  - sof_out is high together with beat 0.
  - Outputs are registered. While valid_out=0, dout holds its last value.
- Overflow: impossible by construction. A frame takes at least 32 input beats and the read drains in 32 cycles. full[wbank] is never 1 when a write frame starts.
  - Add an assertion: write into a full bank is an error.
- Simultaneous events: read-bank clear and write-bank set on the same edge target different banks and must both take effect.
- Reset mid-frame: partial input frame discarded and in-progress output aborted. The next valid_in beat is treated as beat 0.
- Arithmetic: pure data movement. Samples pass bit-exact and signed; no scaling or rounding.

Decomposition:
- Shared package fft_pkg:
  - NUM, N, DW, BEATS = N/NUM;
  - cplx_t struct (signed DW i, q);
  - functions bitrev4, bitrev5, bitrev9.
- One sub-module, fft_reorder_bank:
  - 512 x 2*DW storage;
  - 16-lane scattered write port at the bit-reversed addresses;
  - 16-lane contiguous read port at the beat index.
  - The top instantiates it twice and holds the counters, flags and FSM.

Test Plan:
- Single frame ramp: beat c lane j carries I = bitrev9(16c+j), Q = -I, with valid_in high for 32 cycles. Required:
  - valid_out rises one cycle after the last input beat;
  - output beat k lane m has I = 16k+m, Q = -(16k+m);
  - sof_out on k=0 only;
  - exactly 32 valid beats.
- Back-to-back frames: 3 frames (I offsets 0, 1000 mod 2^DW, constant -5) with valid_in continuously high for 96 cycles. Required:
  - 96 consecutive valid_out cycles;
  - sof_out at beats 0, 32, 64;
  - each frame matches the golden natural order.
- Gapped input: frame 1 with valid_in toggling 1/0 every cycle (64 cycles). Required:
  - output identical to the ramp case;
  - valid_out starts exactly one cycle after the 32nd accepted beat.
- Extremes: all lanes I=+511, Q=-512 on alternate beats. Required: values pass bit-exact, with no sign corruption at the lane boundaries.
- Reset mid-operation: assert rstn=0 for 1 cycle during input beat 17, then drive a full ramp frame. Required:
  - valid_out=0 and dout=0 immediately after reset;
  - no output from the partial frame;
  - the subsequent frame is correct.
- Reset during readout: assert rstn=0 at output beat 10. Required: valid_out drops the next cycle, and a following frame replays correctly starting from bank 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reversal helpers for the FFT output reorder stage.
package fft_pkg;
    localparam int NUM   = 16;
    localparam int N     = 512;
    localparam int DW    = 10;
    localparam int BEATS = N / NUM;
    localparam int CW    = $clog2(BEATS);
    localparam int LW    = $clog2(NUM);
    localparam int AW    = $clog2(N);

    typedef struct packed {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
    } cplx_t;

    typedef enum logic {IDLE, READ} rd_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = x[3-b];
        return r;
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) r[b] = x[4-b];
        return r;
    endfunction

    function automatic logic [8:0] bitrev9(input logic [8:0] x);
        logic [8:0] r;
        for (int b = 0; b < 9; b++) r[b] = x[8-b];
        return r;
    endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of sample storage: scattered bit-reversed write of a whole beat,
// contiguous natural-order read of a whole beat.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [CW-1:0]         wbeat,
    input  cplx_t [NUM-1:0]       wdata,
    input  logic [CW-1:0]         rbeat,
    output cplx_t [NUM-1:0]       rdata
);
    cplx_t mem [0:N-1];

    // Lane j of beat c lands at rev4(j)*32 + rev5(c); lanes never collide.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < NUM; j++)
                mem[{bitrev4(LW'(j)), bitrev5(wbeat)}] <= wdata[j];
        end
    end

    for (genvar m = 0; m < NUM; m++) begin : g_rd
        assign rdata[m] = mem[{rbeat, LW'(m)}];
    end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed butterfly output and replays each
// 512-sample frame in natural order, 16 samples per beat, with no backpressure.
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_in,
    input  logic [DW*NUM-1:0]   din_i,
    input  logic [DW*NUM-1:0]   din_q,
    output logic                valid_out,
    output logic                sof_out,
    output logic [DW*NUM-1:0]   dout_i,
    output logic [DW*NUM-1:0]   dout_q
);
    logic [CW-1:0]          wcnt, rcnt;
    logic                   wbank, rbank;
    logic [1:0]             full, full_nxt;
    logic                   wr_last, rd_last;
    rd_state_t              state;
    cplx_t [NUM-1:0]        wdata;
    cplx_t [1:0][NUM-1:0]   rdata;
    logic [DW*NUM-1:0]      rd_i, rd_q;

    always_comb begin
        wdata = '0;
        for (int j = 0; j < NUM; j++) begin
            wdata[j].i = din_i[j*DW +: DW];
            wdata[j].q = din_q[j*DW +: DW];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank u_bank (
            .clk   (clk),
            .we    (valid_in && (wbank == 1'(b))),
            .wbeat (wcnt),
            .wdata (wdata),
            .rbeat (rcnt),
            .rdata (rdata[b])
        );
    end

    always_comb begin
        rd_i = '0;
        rd_q = '0;
        for (int m = 0; m < NUM; m++) begin
            rd_i[m*DW +: DW] = rdata[rbank][m].i;
            rd_q[m*DW +: DW] = rdata[rbank][m].q;
        end
    end

    // Set and clear always hit different banks, so both land on the same edge.
    always_comb begin
        wr_last  = valid_in && (wcnt == CW'(BEATS-1));
        rd_last  = (state == READ) && (rcnt == CW'(BEATS-1));
        full_nxt = full;
        if (wr_last) full_nxt[wbank] = 1'b1;
        if (rd_last) full_nxt[rbank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            rcnt      <= '0;
            rbank     <= 1'b0;
            full      <= '0;
            state     <= IDLE;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            dout_i    <= '0;
            dout_q    <= '0;
        end else begin
            full <= full_nxt;
            if (valid_in) begin
                wcnt <= wcnt + 1'b1;
                if (wr_last) wbank <= ~wbank;
            end
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    sof_out   <= 1'b0;
                    if (full_nxt[rbank]) begin
                        state <= READ;
                        rcnt  <= '0;
                    end
                end
                READ: begin
                    valid_out <= 1'b1;
                    sof_out   <= (rcnt == '0);
                    dout_i    <= rd_i;
                    dout_q    <= rd_q;
                    rcnt      <= rcnt + 1'b1;
                    if (rd_last) begin
                        rbank <= ~rbank;
                        // Next frame already complete: continue with no gap.
                        if (!full_nxt[~rbank]) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_overwrite: assert property (@(posedge clk) disable iff (!rstn)
        !(valid_in && full[wbank]));
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench with a scoreboard: stimulus pushes expected natural-order beats,
// a monitor pops and compares them (data, sof, exact arrival cycle).
module tb_fft_bitrev_reorder;
    localparam int L  = 16;
    localparam int W  = 10;
    localparam int VW = L * W;

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid_in;
    logic [VW-1:0] din_i, din_q;
    logic          valid_out, sof_out;
    logic [VW-1:0] dout_i, dout_q;

    typedef struct {
        logic [VW-1:0] ei;
        logic [VW-1:0] eq;
        logic          sof;
        int            cyc;
        int            tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    fft_bitrev_reorder dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .din_i     (din_i),
        .din_q     (din_q),
        .valid_out (valid_out),
        .sof_out   (sof_out),
        .dout_i    (dout_i),
        .dout_q    (dout_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rev(input int x, input int w);
        int r = 0;
        for (int b = 0; b < w; b++) if (x[b]) r |= 1 << (w - 1 - b);
        return r;
    endfunction

    // Golden value of natural-index sample p for each frame pattern.
    function automatic void sample(input int mode, input int p,
                                   output logic [W-1:0] vi, output logic [W-1:0] vq);
        int c;
        case (mode)
            0: vi = W'(p);
            1: vi = W'((p + 1000) % 1024);
            2: vi = W'(-5);
            default: begin
                c = rev(p % 32, 5);
                vi = (c % 2 == 0) ? W'(511) : W'(-512);
            end
        endcase
        vq = (mode == 3) ? ~vi : -vi;
    endfunction

    task automatic drive_beat(input int mode, input int c);
        logic [W-1:0] vi, vq;
        @(negedge clk);
        for (int j = 0; j < L; j++) begin
            sample(mode, rev(16 * c + j, 9), vi, vq);
            din_i[j*W +: W] = vi;
            din_q[j*W +: W] = vq;
        end
        valid_in = 1'b1;
    endtask

    task automatic push_frame(input int mode, input int e, input int tag);
        exp_t x;
        logic [W-1:0] vi, vq;
        for (int k = 0; k < 32; k++) begin
            for (int m = 0; m < L; m++) begin
                sample(mode, 16 * k + m, vi, vq);
                x.ei[m*W +: W] = vi;
                x.eq[m*W +: W] = vq;
            end
            x.sof = (k == 0);
            x.cyc = e + 1 + k;
            x.tag = tag;
            sb.push_back(x);
        end
    endtask

    task automatic send_frame(input int mode, input bit gapped, input int tag, output int last_e);
        last_e = 0;
        for (int c = 0; c < 32; c++) begin
            drive_beat(mode, c);
            if (c == 31) begin
                last_e = cyc + 1;
                push_frame(mode, last_e, tag);
            end else if (gapped) begin
                @(negedge clk);
                valid_in = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        idle(40);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected beats never appeared (required 0)", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (valid_out !== 1'b0 || sof_out !== 1'b0 || dout_i !== '0 || dout_q !== '0) begin
            errors++;
            $display("FAIL %s: valid_out=%b sof_out=%b dout_i=%h dout_q=%h, required all 0",
                     name, valid_out, sof_out, dout_i, dout_q);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (valid_out !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: valid_out=%b at cycle %0d, required 0", valid_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                checks += 3;
                if (dout_i !== mon_e.ei || dout_q !== mon_e.eq) begin
                    errors++;
                    $display("FAIL data frame%0d: got i=%h q=%h required i=%h q=%h",
                             mon_e.tag, dout_i, dout_q, mon_e.ei, mon_e.eq);
                end
                if (sof_out !== mon_e.sof) begin
                    errors++;
                    $display("FAIL sof frame%0d: got %b required %b", mon_e.tag, sof_out, mon_e.sof);
                end
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL timing frame%0d: beat at cycle %0d required cycle %0d",
                             mon_e.tag, cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        int e, guard;
        rstn = 1'b0;
        valid_in = 1'b0;
        din_i = '0;
        din_q = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_quiet("reset_state");

        send_frame(0, 1'b0, 1, e);
        drain("ramp");

        send_frame(0, 1'b0, 2, e);
        send_frame(1, 1'b0, 3, e);
        send_frame(2, 1'b0, 4, e);
        drain("back_to_back");

        send_frame(0, 1'b1, 5, e);
        drain("gapped");

        send_frame(3, 1'b0, 6, e);
        drain("extremes");

        for (int c = 0; c < 17; c++) drive_beat(0, c);
        drive_beat(0, 17);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        valid_in = 1'b0;
        check_quiet("reset_mid_input");
        idle(40);
        send_frame(0, 1'b0, 7, e);
        drain("after_input_reset");

        send_frame(0, 1'b0, 8, e);
        guard = 0;
        while (cyc != e + 10 && guard < 50) begin
            @(negedge clk);
            valid_in = 1'b0;
            guard++;
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_quiet("reset_mid_output");
        checks++;
        if (sb.size() != 22) begin
            errors++;
            $display("FAIL readout_abort: %0d beats outstanding, required 22", sb.size());
        end
        sb.delete();
        idle(5);
        send_frame(1, 1'b0, 9, e);
        drain("after_output_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
